ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/core_pkg.sv | 20 ++
 rtl/ex_forward_unit.sv | 17 +
 rtl/ex_operand_stage.sv | 96 +++++++++
 tb/tb_ex_operand_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared datapath widths, ALU opcodes and forward-select encodings
package core_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_op_e;
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;
endpackage

// File: rtl/ex_forward_unit.sv
// ex_forward_unit: picks the freshest source for one register operand
// ports: rs_i (source index), exmem_*/memwb_* (writer enables and indices), sel_o (00 reg, 01 MEM/WB, 10 EX/MEM)
module ex_forward_unit import core_pkg::*; #(
    parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  exmem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr_i,
    input  logic                  memwb_reg_write_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr_i,
    output logic [1:0]            sel_o
);
    logic nz;
    assign nz    = rs_i != '0;
    assign sel_o = (nz && exmem_reg_write_i && exmem_rd_addr_i == rs_i) ? FWD_EXMEM :
                   (nz && memwb_reg_write_i && memwb_rd_addr_i == rs_i) ? FWD_MEMWB : FWD_REG;
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with operand forwarding and load-use detection
// ports: clk_i/rst_ni, id_* decoded instruction, stall_i/flush_i, exmem_*/memwb_* forward sources,
//        operand1_o/operand2_o/alu_control_o ALU inputs, ex_* registered EX state, load_use_hazard_o
module ex_operand_stage import core_pkg::*; #(
    parameter int XLEN       = core_pkg::XLEN,
    parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  id_valid_i,
    input  logic [XLEN-1:0]       id_pc_i,
    input  logic [XLEN-1:0]       id_imm_i,
    input  logic [XLEN-1:0]       id_rs1_data_i,
    input  logic [XLEN-1:0]       id_rs2_data_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic [3:0]            id_alu_control_i,
    input  logic                  id_alu_src_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  id_mem_write_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  exmem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr_i,
    input  logic [XLEN-1:0]       exmem_alu_result_i,
    input  logic                  memwb_reg_write_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr_i,
    input  logic [XLEN-1:0]       memwb_result_i,
    output logic [XLEN-1:0]       operand1_o,
    output logic [XLEN-1:0]       operand2_o,
    output logic [3:0]            alu_control_o,
    output logic                  ex_valid_o,
    output logic [XLEN-1:0]       ex_pc_o,
    output logic [XLEN-1:0]       ex_store_data_o,
    output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
    output logic                  ex_reg_write_o,
    output logic                  ex_mem_read_o,
    output logic                  ex_mem_write_o,
    output logic                  load_use_hazard_o
);
    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [3:0]            alu;
        logic                  alu_src;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } idex_t;
    idex_t d, q;
    logic [1:0] sel1, sel2;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    assign d = '{valid: id_valid_i, pc: id_pc_i, imm: id_imm_i,
                 rs1_data: id_rs1_data_i, rs2_data: id_rs2_data_i,
                 rs1: id_rs1_addr_i, rs2: id_rs2_addr_i, rd: id_rd_addr_i,
                 alu: id_alu_control_i, alu_src: id_alu_src_i,
                 reg_write: id_reg_write_i & id_valid_i,
                 mem_read: id_mem_read_i & id_valid_i,
                 mem_write: id_mem_write_i & id_valid_i};
    // An all-zero record is the bubble: invalid, no side effects, rd 0, opcode AND.
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)
            q <= '0;
        else if (flush_i)
            q <= '0;
        else if (!stall_i)
            q <= d;
    ex_forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd1 (
        .rs_i(q.rs1), .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_addr_i(exmem_rd_addr_i),
        .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_addr_i(memwb_rd_addr_i), .sel_o(sel1));
    ex_forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd2 (
        .rs_i(q.rs2), .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_addr_i(exmem_rd_addr_i),
        .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_addr_i(memwb_rd_addr_i), .sel_o(sel2));
    assign rs1_fwd = sel1 == FWD_EXMEM ? exmem_alu_result_i : sel1 == FWD_MEMWB ? memwb_result_i : q.rs1_data;
    assign rs2_fwd = sel2 == FWD_EXMEM ? exmem_alu_result_i : sel2 == FWD_MEMWB ? memwb_result_i : q.rs2_data;
    assign operand1_o        = rs1_fwd;
    assign operand2_o        = q.alu_src ? q.imm : rs2_fwd;
    assign ex_store_data_o   = rs2_fwd;
    assign alu_control_o     = q.alu;
    assign ex_valid_o        = q.valid;
    assign ex_pc_o           = q.pc;
    assign ex_rd_addr_o      = q.rd;
    assign ex_reg_write_o    = q.reg_write;
    assign ex_mem_read_o     = q.mem_read;
    assign ex_mem_write_o    = q.mem_write;
    assign load_use_hazard_o = q.valid && q.mem_read && q.rd != '0 && id_valid_i &&
                               (q.rd == id_rs1_addr_i || q.rd == id_rs2_addr_i);
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed and random checks of ex_operand_stage against an instruction-level model
module tb_ex_operand_stage;
    logic clk_i = 0, rst_ni = 0;
    logic id_valid_i = 0;
    logic [31:0] id_pc_i = 0, id_imm_i = 0, id_rs1_data_i = 0, id_rs2_data_i = 0;
    logic [4:0] id_rs1_addr_i = 0, id_rs2_addr_i = 0, id_rd_addr_i = 0;
    logic [3:0] id_alu_control_i = 0;
    logic id_alu_src_i = 0, id_reg_write_i = 0, id_mem_read_i = 0, id_mem_write_i = 0;
    logic stall_i = 0, flush_i = 0;
    logic exmem_reg_write_i = 0, memwb_reg_write_i = 0;
    logic [4:0] exmem_rd_addr_i = 0, memwb_rd_addr_i = 0;
    logic [31:0] exmem_alu_result_i = 0, memwb_result_i = 0;
    logic [31:0] operand1_o, operand2_o, ex_pc_o, ex_store_data_o;
    logic [3:0] alu_control_o;
    logic [4:0] ex_rd_addr_o;
    logic ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, load_use_hazard_o;
    int n_assert = 0, n_fail = 0;

    typedef struct {
        bit valid;
        logic [31:0] pc, imm, d1, d2;
        logic [4:0] a1, a2, rd;
        logic [3:0] alu;
        bit src, rw, mr, mw;
    } instr_t;
    instr_t ex;

    ex_operand_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_imm_i(id_imm_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_rs1_addr_i(id_rs1_addr_i),
        .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i), .id_alu_control_i(id_alu_control_i),
        .id_alu_src_i(id_alu_src_i), .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i), .stall_i(stall_i), .flush_i(flush_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_addr_i(exmem_rd_addr_i),
        .exmem_alu_result_i(exmem_alu_result_i), .memwb_reg_write_i(memwb_reg_write_i),
        .memwb_rd_addr_i(memwb_rd_addr_i), .memwb_result_i(memwb_result_i), .operand1_o(operand1_o),
        .operand2_o(operand2_o), .alu_control_o(alu_control_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_store_data_o(ex_store_data_o), .ex_rd_addr_o(ex_rd_addr_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o), .load_use_hazard_o(load_use_hazard_o));

    always #5 clk_i = ~clk_i;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value a source register really holds: youngest in-flight writer wins, x0 is never overridden.
    function automatic logic [31:0] fwd(logic [4:0] rs, logic [31:0] rf);
        if (rs == 0) return rf;
        if (exmem_reg_write_i && exmem_rd_addr_i == rs) return exmem_alu_result_i;
        if (memwb_reg_write_i && memwb_rd_addr_i == rs) return memwb_result_i;
        return rf;
    endfunction

    task automatic check_all(string tag);
        chk({tag, "_valid"}, ex_valid_o, ex.valid);
        chk({tag, "_rw"}, ex_reg_write_o, ex.rw);
        chk({tag, "_mr"}, ex_mem_read_o, ex.mr);
        chk({tag, "_mw"}, ex_mem_write_o, ex.mw);
        chk({tag, "_alu"}, alu_control_o, ex.alu);
        chk({tag, "_rd"}, ex_rd_addr_o, ex.rd);
        chk({tag, "_haz"}, load_use_hazard_o, ex.valid && ex.mr && ex.rd != 0 && id_valid_i &&
                                              (ex.rd == id_rs1_addr_i || ex.rd == id_rs2_addr_i));
        if (ex.valid) begin
            chk({tag, "_pc"}, ex_pc_o, ex.pc);
            chk({tag, "_op1"}, operand1_o, fwd(ex.a1, ex.d1));
            chk({tag, "_op2"}, operand2_o, ex.src ? ex.imm : fwd(ex.a2, ex.d2));
            chk({tag, "_st"}, ex_store_data_o, fwd(ex.a2, ex.d2));
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk_i);
        if (!rst_ni) ex = '{default: 0};
        else if (flush_i) ex = '{default: 0};
        else if (!stall_i)
            ex = '{valid: id_valid_i, pc: id_pc_i, imm: id_imm_i, d1: id_rs1_data_i, d2: id_rs2_data_i,
                   a1: id_rs1_addr_i, a2: id_rs2_addr_i, rd: id_rd_addr_i, alu: id_alu_control_i,
                   src: id_alu_src_i, rw: id_reg_write_i && id_valid_i, mr: id_mem_read_i && id_valid_i,
                   mw: id_mem_write_i && id_valid_i};
        @(negedge clk_i);
        check_all(tag);
    endtask

    task automatic drive(bit v, logic [31:0] pc, logic [4:0] a1, logic [31:0] d1, logic [4:0] a2,
                         logic [31:0] d2, logic [4:0] rd, logic [3:0] alu, bit src, bit rw, bit mr, bit mw);
        id_valid_i = v; id_pc_i = pc; id_rs1_addr_i = a1; id_rs1_data_i = d1; id_rs2_addr_i = a2;
        id_rs2_data_i = d2; id_rd_addr_i = rd; id_alu_control_i = alu; id_alu_src_i = src;
        id_reg_write_i = rw; id_mem_read_i = mr; id_mem_write_i = mw; id_imm_i = 32'h0000_0abc;
    endtask

    task automatic randomize_inputs();
        drive(1'($urandom), $urandom, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom));
        id_imm_i = $urandom;
        stall_i = $urandom_range(0, 4) == 0;
        flush_i = $urandom_range(0, 9) == 0;
        exmem_reg_write_i = 1'($urandom); exmem_rd_addr_i = 5'($urandom_range(0, 7));
        exmem_alu_result_i = $urandom;
        memwb_reg_write_i = 1'($urandom); memwb_rd_addr_i = 5'($urandom_range(0, 7));
        memwb_result_i = $urandom;
    endtask

    initial begin
        ex = '{default: 0};
        repeat (2) @(negedge clk_i);
        check_all("reset");
        chk("reset_op1", operand1_o, 0);
        chk("reset_op2", operand2_o, 0);
        rst_ni = 1;
        // ADD x3(5) + x4(7), no forwarding
        drive(1, 32'h40, 3, 5, 4, 7, 1, 4'b0010, 0, 1, 0, 0);
        tick("add");
        chk("add_op1", operand1_o, 5);
        chk("add_op2", operand2_o, 7);
        chk("add_alu", alu_control_o, 4'b0010);
        chk("add_valid", ex_valid_o, 1);
        // both sources write x3: EX/MEM wins, then MEM/WB alone
        exmem_reg_write_i = 1; exmem_rd_addr_i = 3; exmem_alu_result_i = 32'h10;
        memwb_reg_write_i = 1; memwb_rd_addr_i = 3; memwb_result_i = 32'h20;
        #1 chk("prio_op1", operand1_o, 32'h10);
        chk("prio_st", ex_store_data_o, 7);
        exmem_reg_write_i = 0;
        #1 chk("memwb_op1", operand1_o, 32'h20);
        memwb_reg_write_i = 0;
        // x0 is never forwarded
        drive(1, 32'h44, 1, 9, 0, 0, 2, 4'b0001, 0, 1, 0, 0);
        tick("x0");
        exmem_reg_write_i = 1; exmem_rd_addr_i = 0; exmem_alu_result_i = 32'hff;
        #1 chk("x0_op2", operand2_o, 0);
        chk("x0_st", ex_store_data_o, 0);
        exmem_reg_write_i = 0;
        // load x5 in EX vs decode readers
        drive(1, 32'h48, 1, 0, 2, 0, 5, 4'b0010, 1, 1, 1, 0);
        tick("load");
        drive(1, 32'h4c, 5, 0, 0, 0, 6, 4'b0010, 0, 1, 0, 0);
        #1 chk("haz_rs1", load_use_hazard_o, 1);
        id_rs1_addr_i = 6; id_rs2_addr_i = 7;
        #1 chk("haz_none", load_use_hazard_o, 0);
        id_rs1_addr_i = 5; id_valid_i = 0;
        #1 chk("haz_inv", load_use_hazard_o, 0);
        // stall holds, stall+flush bubbles
        drive(1, 32'h100, 1, 11, 2, 22, 3, 4'b0011, 0, 1, 0, 1);
        tick("pre_stall");
        stall_i = 1;
        drive(1, 32'h200, 4, 44, 5, 55, 6, 4'b0100, 1, 1, 1, 0);
        tick("stall1");
        chk("stall1_pc", ex_pc_o, 32'h100);
        tick("stall2");
        chk("stall2_pc", ex_pc_o, 32'h100);
        flush_i = 1;
        tick("flush");
        chk("flush_valid", ex_valid_o, 0);
        chk("flush_rw", ex_reg_write_o, 0);
        stall_i = 0; flush_i = 0;
        // asynchronous reset mid-cycle
        drive(1, 32'h300, 1, 1, 2, 2, 9, 4'b0110, 0, 1, 1, 0);
        tick("pre_rst");
        #2 rst_ni = 0;
        #1 chk("arst_valid", ex_valid_o, 0);
        chk("arst_rw", ex_reg_write_o, 0);
        chk("arst_mr", ex_mem_read_o, 0);
        chk("arst_alu", alu_control_o, 0);
        ex = '{default: 0};
        check_all("arst");
        @(negedge clk_i);
        rst_ni = 1;
        tick("post_rst");
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            tick("rand");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
